// File: rtl/fifo_math_pkg.sv
// -----------------------------------------------------------------------------
// fifo_math_pkg
// Shared constants and types for the fifo_math vector blocks.
//   DATA_WIDTH : width of one Q-format element
//   ARRAY_SIZE : default number of elements per vector
//   Q_BITS     : fractional bits of the Q format (used for printing only)
//   vec_t      : one vector; element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
package fifo_math_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ARRAY_SIZE = 3;
   localparam int Q_BITS     = 10;

   // Element-major packing so that vec[k] selects a whole element.
   typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

endpackage

// File: rtl/vec_pack.sv
// -----------------------------------------------------------------------------
// vec_pack
// Pops scalars from a first-word-fall-through FIFO and groups every ARRAY_SIZE
// consecutive words into one vector, written into a downstream vector FIFO
// through a one-slot output register.
//
// Ports:
//   flush     in   pad and emit the partial vector (only with VEC_PACK_FLUSH_EN)
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   in        in   scalar FIFO head word, valid while in_empty=0
//   in_empty  in   scalar FIFO empty
//   in_rd_en  out  scalar FIFO pop (combinational)
//   out_din   out  vector to downstream FIFO, element 0 = first word popped
//   out_wr_en out  downstream write strobe (combinational)
//   out_full  in   downstream FIFO full
//
// Optional build macro: VEC_PACK_FLUSH_EN adds the flush input.
// -----------------------------------------------------------------------------
module vec_pack #(
   parameter int DATA_WIDTH = fifo_math_pkg::DATA_WIDTH,
   parameter int ARRAY_SIZE = fifo_math_pkg::ARRAY_SIZE
) (
`ifdef VEC_PACK_FLUSH_EN
   input  logic                                  flush,
`endif
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [DATA_WIDTH-1:0]                 in,
   input  logic                                  in_empty,
   output logic                                  in_rd_en,
   output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out_din,
   output logic                                  out_wr_en,
   input  logic                                  out_full
);
   import fifo_math_pkg::*;

   localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

   typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] pvec_t;

   pvec_t            r_asm_buf;
   pvec_t            r_out_buf;
   logic [IDX_W-1:0] r_idx;
   logic             r_out_valid;

   logic  w_last;
   logic  w_stall;
   logic  w_pop;
   logic  w_complete;
   logic  w_accum;
   logic  w_load;
   pvec_t w_complete_vec;
   pvec_t w_load_vec;

   assign out_wr_en = r_out_valid & ~out_full;
   assign out_din   = r_out_buf;

   // Only the completing pop needs the slot; earlier words park in r_asm_buf,
   // so popping continues under backpressure until the vector is one short.
   assign w_last     = (r_idx == LAST_IDX);
   assign w_stall    = w_last & r_out_valid & ~out_wr_en;
   assign w_pop      = ~in_empty & ~w_stall & ~reset;
   assign in_rd_en   = w_pop;
   assign w_complete = w_pop & w_last;
   assign w_accum    = w_pop & ~w_last;

   // Completed vector: the incoming word becomes the top element.
   generate
      for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_complete
         if (gi == ARRAY_SIZE - 1) begin : g_tail
            assign w_complete_vec[gi] = in;
         end else begin : g_body
            assign w_complete_vec[gi] = r_asm_buf[gi];
         end
      end
   endgenerate

`ifdef VEC_PACK_FLUSH_EN
   logic  w_flush_go;
   pvec_t w_flush_vec;

   // Flush emits a partial vector; it is ignored at idx=0 or on a completing
   // pop, and waits like a completing pop while the slot is held.
   assign w_flush_go = flush & (r_idx != '0) & ~w_complete
                       & ~(r_out_valid & ~out_wr_en);

   // Kept elements below idx, the word popped this cycle at idx, zeros above.
   always_comb begin
      w_flush_vec = '0;
      for (int k = 0; k < ARRAY_SIZE; k++) begin
         if (IDX_W'(k) < r_idx) begin
            w_flush_vec[k] = r_asm_buf[k];
         end else if ((IDX_W'(k) == r_idx) && w_pop) begin
            w_flush_vec[k] = in;
         end
      end
   end

   assign w_load     = w_complete | w_flush_go;
   assign w_load_vec = w_complete ? w_complete_vec : w_flush_vec;
`else
   assign w_load     = w_complete;
   assign w_load_vec = w_complete_vec;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_asm_buf <= '0;
      end else begin
         for (int k = 0; k < ARRAY_SIZE; k++) begin
            if (w_accum && (r_idx == IDX_W'(k))) begin
               r_asm_buf[k] <= in;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_buf   <= '0;
      end else if (w_load) begin
         // Refill wins over a same-cycle write of the old contents: no bubble.
         r_out_buf   <= w_load_vec;
         r_out_valid <= 1'b1;
         r_idx       <= '0;
      end else begin
         if (out_wr_en) begin
            r_out_valid <= 1'b0;
         end
         if (w_accum) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

endmodule
